// File: rtl/router_fifo_param.sv
// Packet-aware synchronous FIFO for a router output channel.
// Each entry carries a header marker; the read side tracks packet length and error conditions.
module router_fifo_param #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned AFULL_THRESH  = DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 2,
    parameter int unsigned LEN_LSB       = 2
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         soft_reset,
    input  logic                         write_enb,
    input  logic                         read_enb,
    input  logic                         lfd_state,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         data_valid,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_empty,
    output logic                         almost_full,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         pkt_active,
    output logic                         pkt_done,
    output logic                         overflow,
    output logic                         underflow,
    output logic                         pkt_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned LW = DATA_WIDTH - LEN_LSB;
    localparam int unsigned PW = LW + 1;

    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [PW-1:0]         pkt_cnt;

    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH:0]   rd_word;
    logic                  rd_hdr;
    logic [LW-1:0]         rd_len;
    logic [PW-1:0]         pkt_cnt_nxt;
    logic                  pkt_done_nxt;
    logic                  pkt_err_set;

    // Status flags derive from the occupancy register
    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign almost_empty = (count <= CW'(AEMPTY_THRESH));
    assign almost_full  = (count >= CW'(AFULL_THRESH));
    // The parity word keeps the packet marked active while it sits on data_out
    assign pkt_active   = (pkt_cnt != '0) || pkt_done;

    assign wr_acc  = write_enb && !full;
    assign rd_acc  = read_enb && !empty;
    assign rd_word = mem[rd_ptr];
    assign rd_hdr  = rd_word[DATA_WIDTH];
    assign rd_len  = rd_word[DATA_WIDTH-1:LEN_LSB];

    // Packet length tracking on the read side
    always_comb begin
        pkt_cnt_nxt  = pkt_cnt;
        pkt_done_nxt = 1'b0;
        pkt_err_set  = 1'b0;
        if (rd_acc) begin
            if (rd_hdr) begin
                pkt_cnt_nxt = PW'(rd_len) + PW'(1);
                pkt_err_set = (pkt_cnt != '0);
            end else if (pkt_cnt != '0) begin
                pkt_cnt_nxt  = pkt_cnt - PW'(1);
                pkt_done_nxt = (pkt_cnt == PW'(1));
            end else begin
                pkt_err_set = 1'b1;
            end
        end
    end

    // Storage array; deliberately not cleared by either reset
    always_ff @(posedge clock) begin
        if (wr_acc && !soft_reset) begin
            mem[wr_ptr] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pkt_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            pkt_done   <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            pkt_err    <= 1'b0;
        end else if (soft_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pkt_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            pkt_done   <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            pkt_err    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            data_out   <= rd_acc ? rd_word[DATA_WIDTH-1:0] : '0;
            data_valid <= rd_acc;
            pkt_cnt    <= pkt_cnt_nxt;
            pkt_done   <= pkt_done_nxt;
            if (write_enb && full) begin
                overflow <= 1'b1;
            end
            if (read_enb && empty) begin
                underflow <= 1'b1;
            end
            if (pkt_err_set) begin
                pkt_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_router_fifo_param.sv
// Directed bench for router_fifo_param with a queue-based reference model checked every cycle.
module tb_router_fifo_param;

    logic       clock;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [4:0] count;
    logic       pkt_active;
    logic       pkt_done;
    logic       overflow;
    logic       underflow;
    logic       pkt_err;

    int checks = 0;
    int errors = 0;

    router_fifo_param dut (
        .clock        (clock),
        .resetn       (resetn),
        .soft_reset   (soft_reset),
        .write_enb    (write_enb),
        .read_enb     (read_enb),
        .lfd_state    (lfd_state),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .pkt_active   (pkt_active),
        .pkt_done     (pkt_done),
        .overflow     (overflow),
        .underflow    (underflow),
        .pkt_err      (pkt_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {header, data} plus packet bookkeeping
    logic [8:0] q[$];
    logic [7:0] m_dout  = '0;
    bit         m_valid = 0;
    bit         m_done  = 0;
    bit         m_ovf   = 0;
    bit         m_unf   = 0;
    bit         m_perr  = 0;
    int         m_pc    = 0;

    task automatic model_clear();
        q.delete();
        m_dout = '0; m_valid = 0; m_done = 0;
        m_ovf = 0; m_unf = 0; m_perr = 0; m_pc = 0;
    endtask

    always @(negedge resetn) model_clear();

    always @(posedge clock) begin
        if (!resetn || soft_reset) begin
            model_clear();
        end else begin
            bit was_full, was_empty;
            logic [8:0] w;
            was_full  = (q.size() == 16);
            was_empty = (q.size() == 0);
            if (write_enb && was_full) m_ovf = 1;
            if (read_enb && was_empty) m_unf = 1;
            m_dout = '0; m_valid = 0; m_done = 0;
            if (read_enb && !was_empty) begin
                w = q.pop_front();
                m_dout  = w[7:0];
                m_valid = 1;
                if (w[8]) begin
                    if (m_pc != 0) m_perr = 1;
                    m_pc = int'(w[7:2]) + 1;
                end else if (m_pc > 0) begin
                    m_pc--;
                    if (m_pc == 0) m_done = 1;
                end else begin
                    m_perr = 1;
                end
            end
            if (write_enb && !was_full) q.push_back({lfd_state, data_in});
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle
    always @(negedge clock) begin
        if (resetn) begin
            chk("data_out",     32'(data_out),     32'(m_dout));
            chk("data_valid",   32'(data_valid),   32'(m_valid));
            chk("count",        32'(count),        32'(q.size()));
            chk("empty",        32'(empty),        32'(q.size() == 0));
            chk("full",         32'(full),         32'(q.size() == 16));
            chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
            chk("almost_full",  32'(almost_full),  32'(q.size() >= 14));
            chk("pkt_active",   32'(pkt_active),   32'(m_pc != 0 || m_done));
            chk("pkt_done",     32'(pkt_done),     32'(m_done));
            chk("overflow",     32'(overflow),     32'(m_ovf));
            chk("underflow",    32'(underflow),    32'(m_unf));
            chk("pkt_err",      32'(pkt_err),      32'(m_perr));
        end
    end

    // Apply one cycle of inputs; returns 2 time units after the edge
    task automatic op(input bit we, input bit re, input bit lfd, input logic [7:0] d, input bit sr);
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = d;
        soft_reset = sr;
        @(posedge clock);
        #2;
        write_enb  = 0;
        read_enb   = 0;
        lfd_state  = 0;
        soft_reset = 0;
    endtask

    logic [7:0] arr [16];

    initial begin
        resetn = 0; soft_reset = 0; write_enb = 0; read_enb = 0; lfd_state = 0; data_in = '0;
        @(posedge clock); #2;
        chk("rst data_out", 32'(data_out), 32'h0);
        chk("rst empty", 32'(empty), 32'h1);
        chk("rst almost_empty", 32'(almost_empty), 32'h1);
        chk("rst full", 32'(full), 32'h0);
        chk("rst pkt_active", 32'(pkt_active), 32'h0);
        chk("rst overflow", 32'(overflow), 32'h0);
        resetn = 1;
        @(posedge clock); #2;

        // 1. asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) op(1, 0, 0, 8'(i + 1), 0);
        op(0, 1, 0, 8'h00, 0);
        chk("t1 first read", 32'(data_out), 32'h01);
        resetn = 0;
        #1;
        chk("t1 async empty", 32'(empty), 32'h1);
        chk("t1 async count", 32'(count), 32'h0);
        chk("t1 async valid", 32'(data_valid), 32'h0);
        #1;
        resetn = 1;
        op(0, 1, 0, 8'h00, 0);
        chk("t1 underflow", 32'(underflow), 32'h1);

        // 2. fill, overflow, drain, wrap
        op(0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 16; i++) begin
            arr[i] = 8'($urandom);
            op(1, 0, 0, arr[i], 0);
            if (i == 12) chk("t2 afull at 13", 32'(almost_full), 32'h0);
            if (i == 13) chk("t2 afull at 14", 32'(almost_full), 32'h1);
        end
        chk("t2 full", 32'(full), 32'h1);
        chk("t2 count16", 32'(count), 32'd16);
        op(1, 0, 0, 8'hEE, 0);
        chk("t2 overflow", 32'(overflow), 32'h1);
        chk("t2 count stays", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            op(0, 1, 0, 8'h00, 0);
            chk("t2 drain data", 32'(data_out), 32'(arr[i]));
        end
        chk("t2 empty", 32'(empty), 32'h1);
        for (int i = 0; i < 12; i++) op(1, 0, 0, 8'(8'h40 + i), 0);
        for (int i = 0; i < 12; i++) op(0, 1, 0, 8'h00, 0);
        for (int i = 0; i < 8; i++) op(1, 0, 0, 8'(8'hA0 + i), 0);
        for (int i = 0; i < 8; i++) begin
            op(0, 1, 0, 8'h00, 0);
            chk("t2 wrap data", 32'(data_out), 32'(8'hA0 + i));
        end

        // 3. simultaneous read and write
        op(0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 4; i++) op(1, 0, 0, 8'(8'h10 + i), 0);
        for (int i = 0; i < 10; i++) begin
            op(1, 1, 0, 8'(8'h20 + i), 0);
            chk("t3 count4", 32'(count), 32'd4);
        end
        chk("t3 order", 32'(data_out), 32'h25);
        for (int i = 0; i < 12; i++) op(1, 0, 0, 8'(8'h30 + i), 0);
        op(1, 1, 0, 8'hFF, 0);
        chk("t3 full rw count", 32'(count), 32'd15);
        chk("t3 full rw ovf", 32'(overflow), 32'h1);
        chk("t3 full rw valid", 32'(data_valid), 32'h1);
        op(0, 0, 0, 8'h00, 1);
        op(1, 1, 0, 8'h5A, 0);
        chk("t3 empty rw count", 32'(count), 32'd1);
        chk("t3 empty rw unf", 32'(underflow), 32'h1);
        chk("t3 empty rw valid", 32'(data_valid), 32'h0);

        // 4. packet tracking: header length 3, three payload words, parity
        op(0, 0, 0, 8'h00, 1);
        op(1, 0, 1, 8'h0C, 0);
        op(1, 0, 0, 8'h11, 0);
        op(1, 0, 0, 8'h22, 0);
        op(1, 0, 0, 8'h33, 0);
        op(1, 0, 0, 8'h44, 0);
        for (int i = 0; i < 5; i++) begin
            op(0, 1, 0, 8'h00, 0);
            chk("t4 pkt_active", 32'(pkt_active), 32'h1);
            chk("t4 pkt_done", 32'(pkt_done), 32'(i == 4));
        end
        chk("t4 parity data", 32'(data_out), 32'h44);
        op(0, 0, 0, 8'h00, 0);
        chk("t4 idle active", 32'(pkt_active), 32'h0);
        chk("t4 no err", 32'(pkt_err), 32'h0);

        // 5. header arriving mid-packet
        op(0, 0, 0, 8'h00, 1);
        op(1, 0, 1, 8'h08, 0);
        op(1, 0, 0, 8'h55, 0);
        op(1, 0, 1, 8'h04, 0);
        op(1, 0, 0, 8'h66, 0);
        op(1, 0, 0, 8'h77, 0);
        for (int i = 0; i < 3; i++) op(0, 1, 0, 8'h00, 0);
        chk("t5 pkt_err", 32'(pkt_err), 32'h1);
        chk("t5 hdr data", 32'(data_out), 32'h04);
        op(0, 1, 0, 8'h00, 0);
        chk("t5 not done", 32'(pkt_done), 32'h0);
        op(0, 1, 0, 8'h00, 0);
        chk("t5 done after 2", 32'(pkt_done), 32'h1);

        // 6. soft reset with simultaneous traffic
        op(0, 0, 0, 8'h00, 1);
        op(0, 1, 0, 8'h00, 0);
        op(1, 0, 1, 8'h0C, 0);
        for (int i = 0; i < 10; i++) op(1, 0, 0, 8'(8'h80 + i), 0);
        op(0, 1, 0, 8'h00, 0);
        op(0, 1, 0, 8'h00, 0);
        chk("t6 count9", 32'(count), 32'd9);
        chk("t6 mid pkt", 32'(pkt_active), 32'h1);
        op(1, 1, 0, 8'hAB, 1);
        chk("t6 count", 32'(count), 32'h0);
        chk("t6 empty", 32'(empty), 32'h1);
        chk("t6 pkt_active", 32'(pkt_active), 32'h0);
        chk("t6 valid", 32'(data_valid), 32'h0);
        chk("t6 underflow", 32'(underflow), 32'h0);
        chk("t6 overflow", 32'(overflow), 32'h0);
        chk("t6 pkt_err", 32'(pkt_err), 32'h0);
        op(0, 0, 0, 8'h00, 0);

        @(posedge clock); #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
